// File: rtl/br_ctrl_if.sv
// Fetch/execute/redirect signal bundle for the branch-prediction controller.
// The master drives the pipeline-side inputs and the slave is the controller.
interface br_ctrl_if;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_ir;
  logic        pr_taken;
  logic [63:0] pr_addr;
  logic        ex_branch;
  logic [63:0] ex_pc;
  logic        ex_brc;
  logic        ex_pr_miss;
  logic [63:0] ex_br_addr;
  logic        ex_jalr_taken;
  logic [63:0] ex_jalr_addr;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_addr;
  logic        flush;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output if_valid, if_pc, if_ir,
    output ex_branch, ex_pc, ex_brc, ex_pr_miss, ex_br_addr,
    output ex_jalr_taken, ex_jalr_addr, stall,
    input  pr_taken, pr_addr, redirect, redirect_addr, flush, br_cnt, miss_cnt
  );

  modport slave (
    input  if_valid, if_pc, if_ir,
    input  ex_branch, ex_pc, ex_brc, ex_pr_miss, ex_br_addr,
    input  ex_jalr_taken, ex_jalr_addr, stall,
    output pr_taken, pr_addr, redirect, redirect_addr, flush, br_cnt, miss_cnt
  );
endinterface

// File: rtl/br_ctrl.sv
// Branch predictor (2-bit BHT) plus redirect/flush sequencer and statistics.
// state  | meaning
// IDLE   | accepting execute-side resolutions, BHT updates and redirects
// REDIR  | redirect strobe and flush for one cycle
// SHADOW | flush only; execute-side inputs are wrong-path and ignored
module br_ctrl #(
  parameter int BHT_IDX = 6
) (
  input logic       clk,
  input logic       rst_n,
  br_ctrl_if.slave  bus
);

  localparam int BHT_N = 1 << BHT_IDX;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDIR  = 2'd1,
    SHADOW = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          bht_q [BHT_N];
  logic [63:0]         redir_addr_q, redir_addr_d;
  logic [31:0]         br_cnt_q, br_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;
  logic                bht_we;
  logic [1:0]          bht_wdata;
  logic                redirect_c, flush_c;
  logic [BHT_IDX-1:0]  if_idx, ex_idx;
  logic [1:0]          if_ctr, ex_ctr;
  logic                if_is_br;
  logic                pr_taken_c;
  logic [63:0]         b_imm;
  logic                unused_bits;

  assign if_idx   = bus.if_pc[BHT_IDX+1:2];
  assign ex_idx   = bus.ex_pc[BHT_IDX+1:2];
  assign if_ctr   = bht_q[if_idx];
  assign ex_ctr   = bht_q[ex_idx];
  assign if_is_br = (bus.if_ir[6:0] == 7'b1100011);

  // Reads the registered table, so a same-cycle update is not visible here.
  assign pr_taken_c = bus.if_valid & if_is_br & if_ctr[1];
  assign b_imm = {{52{bus.if_ir[31]}}, bus.if_ir[7], bus.if_ir[30:25],
                  bus.if_ir[11:8], 1'b0};

  assign bus.pr_taken      = pr_taken_c;
  assign bus.pr_addr       = pr_taken_c ? (bus.if_pc + b_imm) : (bus.if_pc + 64'd4);
  assign bus.redirect      = redirect_c;
  assign bus.flush         = flush_c;
  assign bus.redirect_addr = redir_addr_q;
  assign bus.br_cnt        = br_cnt_q;
  assign bus.miss_cnt      = miss_cnt_q;

  assign unused_bits = ^{bus.if_pc[63:BHT_IDX+2], bus.if_pc[1:0],
                         bus.ex_pc[63:BHT_IDX+2], bus.ex_pc[1:0],
                         bus.if_ir[24:12]};

  always_comb begin
    state_d      = state_q;
    redir_addr_d = redir_addr_q;
    br_cnt_d     = br_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    bht_we       = 1'b0;
    bht_wdata    = ex_ctr;
    redirect_c   = 1'b0;
    flush_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.stall) begin
          if (bus.ex_branch) begin
            bht_we = 1'b1;
            if (bus.ex_brc)
              bht_wdata = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
            else
              bht_wdata = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;
            if (br_cnt_q != 32'hFFFF_FFFF)
              br_cnt_d = br_cnt_q + 32'd1;
          end
          // A mispredicted branch outranks a simultaneous JALR.
          if (bus.ex_pr_miss) begin
            state_d      = REDIR;
            redir_addr_d = bus.ex_br_addr;
            if (miss_cnt_q != 32'hFFFF_FFFF)
              miss_cnt_d = miss_cnt_q + 32'd1;
          end else if (bus.ex_jalr_taken) begin
            state_d      = REDIR;
            redir_addr_d = bus.ex_jalr_addr;
          end
        end
      end
      REDIR: begin
        redirect_c = 1'b1;
        flush_c    = 1'b1;
        state_d    = SHADOW;
      end
      SHADOW: begin
        flush_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      redir_addr_q <= 64'd0;
      br_cnt_q     <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      redir_addr_q <= redir_addr_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Table resets to weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[ex_idx] <= bht_wdata;
    end
  end

endmodule

// File: doc/br_ctrl.md
BR_CTRL -- requirements
Module: br_ctrl

Interface
REQ-001 The parameter list SHALL be: BHT_IDX, default 6, log2 of branch history table (BHT) entries.
REQ-002 Ports SHALL be, clock and reset first: clk  in  1  core clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_valid  in  1  fetch-stage instruction valid.
REQ-005 if_pc  in  64  fetch-stage PC.
REQ-006 if_ir  in  32  fetch-stage instruction word.
REQ-007 pr_taken  out  1  fetch-stage taken prediction, carried down the pipe to the branch ALU.
REQ-008 pr_addr  out  64  fetch-stage next-PC per prediction.
REQ-009 ex_branch  in  1  execute stage holds a conditional branch (opcode 1100011).
REQ-010 ex_pc  in  64  execute-stage PC.
REQ-011 ex_brc  in  1  resolved branch condition.
REQ-012 ex_pr_miss  in  1  prediction miss from the branch ALU.
REQ-013 ex_br_addr  in  64  corrected branch target.
REQ-014 ex_jalr_taken  in  1  JALR in execute.
REQ-015 ex_jalr_addr  in  64  JALR target.
REQ-016 stall  in  1  pipeline stall; freezes execute-side inputs.
REQ-017 redirect  out  1  one-cycle PC redirect strobe.
REQ-018 redirect_addr  out  64  redirect target, valid while redirect=1.
REQ-019 flush  out  1  squash fetch and decode stages.
REQ-020 br_cnt, miss_cnt  out  32 each  resolved-branch and miss counters.

Function
REQ-021 The BHT SHALL hold 2^BHT_IDX 2-bit saturating counters, indexed by pc[BHT_IDX+1:2].
REQ-022 pr_taken SHALL be combinational and equal 1 when all of the following hold: if_valid=1, if_ir[6:0]=1100011, and the BHT counter bit[1] at if_pc's index is 1.
REQ-023 pr_addr SHALL be if_pc + sign-extended B-immediate {ir[31],ir[7],ir[30:25],ir[11:8],0} when pr_taken=1, and if_pc+4 otherwise; arithmetic is modulo 2^64.
REQ-024 The FSM SHALL have states IDLE, REDIR and SHADOW; the reset state is IDLE.
REQ-025 In IDLE, with stall=0, ex_pr_miss=1 or ex_jalr_taken=1 SHALL cause a transition to REDIR and register the target in redirect_addr.
REQ-026 If ex_pr_miss=1 and ex_jalr_taken=1 in the same cycle, ex_br_addr SHALL be selected.
REQ-027 In REDIR, redirect=1 and flush=1 SHALL be asserted for exactly one cycle, followed unconditionally by SHADOW.
REQ-028 In SHADOW, flush=1 and redirect=0 SHALL be asserted for one cycle, followed by IDLE.
REQ-029 Execute-side inputs presented in REDIR or SHADOW are wrong-path and SHALL be ignored: no redirect, no BHT update, no counter increment.
REQ-030 stall=1 SHALL not freeze the FSM once it has left IDLE; REDIR and SHADOW SHALL each last exactly one cycle regardless of stall.
REQ-031 BHT update SHALL occur in IDLE when stall=0 and ex_branch=1, at ex_pc's index: increment toward 11 if ex_brc=1, decrement toward 00 otherwise, saturating at both ends.
REQ-032 When the same index is read at fetch and written at execute in one cycle, the prediction SHALL use the pre-update value.
REQ-033 br_cnt SHALL increment on every accepted BHT update; miss_cnt SHALL increment on every accepted ex_pr_miss; both SHALL saturate at 0xFFFFFFFF.
REQ-034 A JALR redirect SHALL not touch the BHT or either counter.
REQ-035 Redirect latency SHALL be one cycle from the accepted execute-side event to redirect=1.

Reset
REQ-036 On rst_n=0, the following SHALL be forced immediately and asynchronously: FSM=IDLE; redirect=0; flush=0; redirect_addr=0; br_cnt=0; miss_cnt=0; every BHT entry=01 (weakly not-taken).
REQ-037 Reset asserted mid-REDIR or mid-SHADOW SHALL abort the sequence with no further redirect strobe after release.
REQ-038 The first rising edge after rst_n deasserts SHALL see IDLE.

Verification
REQ-039 Scenario: after reset, if_valid=1, if_pc=0x1000, if_ir=BEQ with offset +16 -> pr_taken=0, pr_addr=0x1004.
REQ-040 Scenario: two taken resolutions at ex_pc=0x1000, each ex_pr_miss=1, ex_br_addr=0x1010 -> counter goes 01->10->11; then fetch at 0x1000 gives pr_taken=1, pr_addr=0x1010; miss_cnt=2, br_cnt=2.
REQ-041 Scenario: ex_jalr_taken=1, ex_jalr_addr=0x8000_0000 with stall=0 -> next cycle redirect=1, flush=1, redirect_addr=0x80000000; following cycle redirect=0, flush=1; then flush=0; BHT and counters unchanged.
REQ-042 Scenario: ex_pr_miss=1 during SHADOW -> no redirect and no miss_cnt change.
REQ-043 Scenario: ex_pr_miss=1 with stall=1 in IDLE -> no action until stall drops, then a redirect on the next cycle.
REQ-044 Scenario: rst_n pulsed low during REDIR -> outputs zero immediately, BHT entries read 01, and no redirect follows.
